dce_uart_rx: RTL and testbench

DCE-side UART receiver: the far end of the light UART transactor's txd line. Deserialises 8N1 frames from txd and buffers the bytes in a small FIFO. Presents the bytes on a valid/ready handshake and drives cts for hardware flow control back to the transactor. Sits beside the DCE loopback model in the DUT wrapper and shares that model's 32-bit DBR divisor convention (clock10M cycles per bit).

---
 rtl/dce_uart_pkg.sv | 20 ++
 rtl/dce_uart_fifo.sv | 54 +++++
 rtl/dce_uart_rx.sv | 158 +++++++++++++++
 tb/tb_dce_uart_rx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dce_uart_pkg.sv
// rtl/dce_uart_pkg.sv - shared state enum, frame constants and divisor clamp for dce_uart_rx
package dce_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int          DATA_BITS = 8;
    localparam logic [31:0] MIN_DBR   = 32'd4;

    function automatic logic [31:0] clamp_dbr(input logic [31:0] dbr);
        return (dbr < MIN_DBR) ? MIN_DBR : dbr;
    endfunction

endpackage

// File: rtl/dce_uart_fifo.sv
// rtl/dce_uart_fifo.sv - show-ahead synchronous FIFO; push while full is dropped
module dce_uart_fifo #(
    parameter int  DEPTH = 8,
    parameter int  WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clock10M,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock10M) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clock10M) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dce_uart_rx.sv
// rtl/dce_uart_rx.sv - DCE-side 8N1 UART receiver with receive FIFO and cts flow control
// Optional even-parity bit enabled by DCE_UART_RX_PARITY_EN.
module dce_uart_rx
    import dce_uart_pkg::*;
#(
    parameter int  FIFO_DEPTH  = 8,
    parameter int  CTS_MARGIN  = 2,
    parameter int  SYNC_STAGES = 2,
    localparam int LW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clock10M,
    input  logic          reset,
    input  logic          txd,
    input  logic [31:0]   dbr,
    output logic          cts,
    output logic [7:0]    rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    output logic [LW-1:0] fifo_level,
    output logic          framing_err,
    output logic          overrun_err,
    output logic          parity_err
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   rxd;
    logic                   rxd_prev;
    rx_state_t              state;
    logic [31:0]            cnt;
    logic [31:0]            d_lat;
    logic [2:0]             bit_idx;
    logic [7:0]             shreg;
    logic                   par_bad;
    logic                   push;
    logic                   full;
    logic                   empty;

    assign rxd = sync[SYNC_STAGES-1];

`ifdef DCE_UART_RX_PARITY_EN
    logic par_bit;
    assign par_bad = ((^shreg) != par_bit);
`else
    assign par_bad = 1'b0;
`endif

    // Push combinationally on the good stop sample so the byte shows next cycle.
    assign push     = (state == STOP) && (cnt == '0) && rxd && !par_bad;
    assign rx_valid = !empty;

    dce_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock10M  (clock10M),
        .reset     (reset),
        .push      (push),
        .push_data (shreg),
        .pop       (rx_ready),
        .head      (rx_data),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clock10M) begin
        if (!reset) begin
            sync        <= '1;
            rxd_prev    <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            d_lat       <= MIN_DBR;
            bit_idx     <= '0;
            shreg       <= '0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
            parity_err  <= 1'b0;
`ifdef DCE_UART_RX_PARITY_EN
            par_bit     <= 1'b0;
`endif
        end else begin
            sync        <= {sync[SYNC_STAGES-2:0], txd};
            rxd_prev    <= rxd;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
            parity_err  <= 1'b0;
            if (cnt != '0) cnt <= cnt - 32'd1;
            case (state)
                IDLE: begin
                    if (rxd_prev && !rxd) begin
                        state <= START;
                        d_lat <= clamp_dbr(dbr);
                        cnt   <= (clamp_dbr(dbr) >> 1) - 32'd1;
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        if (!rxd) begin
                            state   <= DATA;
                            cnt     <= d_lat - 32'd1;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        shreg   <= {rxd, shreg[7:1]};
                        cnt     <= d_lat - 32'd1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef DCE_UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef DCE_UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == '0) begin
                        par_bit <= rxd;
                        cnt     <= d_lat - 32'd1;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (cnt == '0) begin
                        if (!rxd) begin
                            framing_err <= 1'b1;
                            state       <= WAIT_IDLE;
                        end else begin
                            parity_err  <= par_bad;
                            overrun_err <= !par_bad && full;
                            state       <= IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rxd) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock10M) begin
        if (!reset) begin
            cts <= 1'b1;
        end else begin
            cts <= (FIFO_DEPTH - int'(fifo_level)) > CTS_MARGIN;
        end
    end

endmodule

// File: tb/tb_dce_uart_rx.sv
// tb/tb_dce_uart_rx.sv - directed table-driven bench for dce_uart_rx
module tb_dce_uart_rx;

`ifdef DCE_UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic        clock10M = 1'b0;
    logic        reset    = 1'b0;
    logic        txd      = 1'b1;
    logic        rx_ready = 1'b0;
    logic [31:0] dbr      = 32'd16;
    logic        cts;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [3:0]  fifo_level;
    logic        framing_err;
    logic        overrun_err;
    logic        parity_err;

    dce_uart_rx #(
        .FIFO_DEPTH  (8),
        .CTS_MARGIN  (2),
        .SYNC_STAGES (2)
    ) dut (
        .clock10M    (clock10M),
        .reset       (reset),
        .txd         (txd),
        .dbr         (dbr),
        .cts         (cts),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .fifo_level  (fifo_level),
        .framing_err (framing_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err)
    );

    always #50 clock10M = ~clock10M;

    int   cyc      = 0;
    int   fe_n     = 0;
    int   ov_n     = 0;
    int   pe_n     = 0;
    int   rise_n   = 0;
    int   rise_cyc = 0;
    logic prev_v   = 1'b0;

    always @(posedge clock10M) cyc <= cyc + 1;

    always @(negedge clock10M) begin
        if (framing_err) fe_n <= fe_n + 1;
        if (overrun_err) ov_n <= ov_n + 1;
        if (parity_err)  pe_n <= pe_n + 1;
        if (rx_valid && !prev_v) begin
            rise_n   <= rise_n + 1;
            rise_cyc <= cyc;
        end
        prev_v <= rx_valid;
    end

    int n_vec = 0;
    int n_bad = 0;
    int start_cyc = 0;
    int f0, o0, p0, r0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int d, input bit bad_par,
                              input bit stop_low, input int stop_cycles);
        @(posedge clock10M); #1;
        txd = 1'b0;
        start_cyc = cyc;
        repeat (d) @(posedge clock10M);
        for (int i = 0; i < 8; i++) begin
            #1 txd = b[i];
            repeat (d) @(posedge clock10M);
        end
        if (PB == 1) begin
            #1 txd = (^b) ^ bad_par;
            repeat (d) @(posedge clock10M);
        end
        #1 txd = !stop_low;
        repeat (stop_cycles) @(posedge clock10M);
        #1 txd = 1'b1;
    endtask

    task automatic pop_one();
        @(posedge clock10M); #1 rx_ready = 1'b1;
        @(posedge clock10M); #1 rx_ready = 1'b0;
    endtask

    task automatic check_byte(input string name, input logic [7:0] exp);
        @(negedge clock10M);
        chk({name, "_valid"}, 32'(rx_valid), 32'd1);
        chk({name, "_data"}, 32'(rx_data), 32'(exp));
        pop_one();
    endtask

    task automatic snap();
        f0 = fe_n; o0 = ov_n; p0 = pe_n; r0 = rise_n;
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [31:0] dbr;
        int          d;
        int          lat;
    } vec_t;

    vec_t vt[8];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vt[0] = '{8'hA5, 32'd16, 16, 155};
        vt[1] = '{8'h81, 32'd2,  4,  41};
        vt[2] = '{8'h00, 32'd16, 16, 155};
        vt[3] = '{8'hFF, 32'd5,  5,  50};
        vt[4] = '{8'h55, 32'd7,  7,  69};
        vt[5] = '{8'h5A, 32'd0,  4,  41};
        vt[6] = '{8'hC3, 32'd3,  4,  41};
        vt[7] = '{8'h96, 32'd31, 31, 297};

        repeat (3) @(posedge clock10M);
        @(negedge clock10M);
        chk("reset_cts", 32'(cts), 32'd1);
        chk("reset_valid", 32'(rx_valid), 32'd0);
        chk("reset_data", 32'(rx_data), 32'd0);
        chk("reset_level", 32'(fifo_level), 32'd0);
        chk("reset_errs", 32'({framing_err, overrun_err, parity_err}), 32'd0);
        @(posedge clock10M); #1 reset = 1'b1;
        repeat (5) @(posedge clock10M);

        for (int i = 0; i < 8; i++) begin
            dbr = vt[i].dbr;
            snap();
            send_frame(vt[i].data, vt[i].d, 1'b0, 1'b0, vt[i].d);
            repeat (4) @(posedge clock10M);
            @(negedge clock10M);
            chk("vec_rise", 32'(rise_n - r0), 32'd1);
            chk("vec_latency", 32'(rise_cyc - start_cyc), 32'(vt[i].lat + PB * vt[i].d));
            chk("vec_level", 32'(fifo_level), 32'd1);
            chk("vec_data", 32'(rx_data), 32'(vt[i].data));
            chk("vec_errs", 32'((fe_n - f0) + (ov_n - o0) + (pe_n - p0)), 32'd0);
            pop_one();
        end

        dbr = 32'd16;
        snap();
        @(posedge clock10M); #1 txd = 1'b0;
        repeat (4) @(posedge clock10M);
        #1 txd = 1'b1;
        repeat (40) @(posedge clock10M);
        @(negedge clock10M);
        chk("glitch_level", 32'(fifo_level), 32'd0);
        chk("glitch_rise", 32'(rise_n - r0), 32'd0);
        chk("glitch_errs", 32'((fe_n - f0) + (ov_n - o0) + (pe_n - p0)), 32'd0);

        snap();
        send_frame(8'h3C, 16, 1'b0, 1'b1, 40);
        repeat (48) @(posedge clock10M);
        @(negedge clock10M);
        chk("framing_pulse", 32'(fe_n - f0), 32'd1);
        chk("framing_other", 32'((ov_n - o0) + (pe_n - p0)), 32'd0);
        chk("framing_level", 32'(fifo_level), 32'd0);
        send_frame(8'h55, 16, 1'b0, 1'b0, 16);
        repeat (4) @(posedge clock10M);
        check_byte("after_break", 8'h55);

        snap();
        fork
            send_frame(8'hC6, 16, 1'b0, 1'b0, 16);
            begin
                repeat (40) @(posedge clock10M);
                #1 dbr = 32'd32;
            end
        join
        repeat (4) @(posedge clock10M);
        @(negedge clock10M);
        chk("dbr_change_latency", 32'(rise_cyc - start_cyc), 32'(155 + PB * 16));
        check_byte("dbr_change", 8'hC6);
        dbr = 32'd16;

        snap();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 16, 1'b0, 1'b0, 16);
        repeat (3) @(posedge clock10M);
        @(negedge clock10M);
        chk("fill5_level", 32'(fifo_level), 32'd5);
        chk("fill5_cts", 32'(cts), 32'd1);
        fork
            send_frame(8'h06, 16, 1'b0, 1'b0, 16);
            begin
                for (int t = 0; t < 400 && fifo_level != 4'd6; t++) @(negedge clock10M);
                chk("fill6_level", 32'(fifo_level), 32'd6);
                chk("fill6_cts_hold", 32'(cts), 32'd1);
                @(negedge clock10M);
                chk("fill6_cts_drop", 32'(cts), 32'd0);
            end
        join
        send_frame(8'h07, 16, 1'b0, 1'b0, 16);
        send_frame(8'h08, 16, 1'b0, 1'b0, 16);
        repeat (3) @(posedge clock10M);
        @(negedge clock10M);
        chk("fill8_level", 32'(fifo_level), 32'd8);
        chk("fill8_ovr", 32'(ov_n - o0), 32'd0);
        send_frame(8'h09, 16, 1'b0, 1'b0, 16);
        repeat (3) @(posedge clock10M);
        @(negedge clock10M);
        chk("overrun_pulse", 32'(ov_n - o0), 32'd1);
        chk("overrun_level", 32'(fifo_level), 32'd8);
        chk("overrun_other", 32'((fe_n - f0) + (pe_n - p0)), 32'd0);
        for (int i = 1; i <= 8; i++) check_byte("drain", 8'(i));
        @(negedge clock10M);
        chk("drain_valid", 32'(rx_valid), 32'd0);
        @(negedge clock10M);
        chk("drain_cts", 32'(cts), 32'd1);

        send_frame(8'h11, 16, 1'b0, 1'b0, 16);
        repeat (3) @(posedge clock10M);
        @(posedge clock10M); #1 txd = 1'b0;
        repeat (60) @(posedge clock10M);
        #1 reset = 1'b0;
        txd = 1'b1;
        repeat (3) @(posedge clock10M);
        #1 reset = 1'b1;
        @(negedge clock10M);
        chk("midreset_level", 32'(fifo_level), 32'd0);
        chk("midreset_valid", 32'(rx_valid), 32'd0);
        chk("midreset_data", 32'(rx_data), 32'd0);
        chk("midreset_cts", 32'(cts), 32'd1);
        repeat (20) @(posedge clock10M);
        send_frame(8'h7E, 16, 1'b0, 1'b0, 16);
        repeat (4) @(posedge clock10M);
        @(negedge clock10M);
        chk("after_reset_level", 32'(fifo_level), 32'd1);
        check_byte("after_reset", 8'h7E);

`ifdef DCE_UART_RX_PARITY_EN
        snap();
        send_frame(8'h7E, 16, 1'b1, 1'b0, 16);
        repeat (4) @(posedge clock10M);
        @(negedge clock10M);
        chk("parity_pulse", 32'(pe_n - p0), 32'd1);
        chk("parity_level", 32'(fifo_level), 32'd0);
        chk("parity_other", 32'((fe_n - f0) + (ov_n - o0)), 32'd0);
`else
        chk("parity_tied", 32'(pe_n), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
